// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory client port between two requesters: requester 0 (fetch
//   unit) and requester 1 (load/store unit). Requests are arbitrated
//   round-robin. The owner of every accepted request is pushed into an
//   in-flight ordering queue. Because the memory answers strictly in request
//   order, the head of that queue names the owner of the next response.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   c0_req_*, c1_req_*       val/rdy/msg request channels from the requesters
//   c0_resp_*, c1_resp_*     val/rdy response channels to the requesters
//   resp_msg                 shared response payload, qualified by cN_resp_val
//   mem_req_*                val/rdy/msg request channel to the memory
//   mem_resp_*               val/rdy/msg response channel from the memory
//   inflight_count           registered count of outstanding requests
module mem_port_arbiter #(
  parameter int p_req_bits     = 101,
  parameter int p_resp_bits    = 101,
  parameter int p_max_inflight = 4
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              c0_req_val,
  output logic                              c0_req_rdy,
  input  logic [p_req_bits-1:0]             c0_req_msg,
  input  logic                              c1_req_val,
  output logic                              c1_req_rdy,
  input  logic [p_req_bits-1:0]             c1_req_msg,

  output logic                              c0_resp_val,
  input  logic                              c0_resp_rdy,
  output logic                              c1_resp_val,
  input  logic                              c1_resp_rdy,
  output logic [p_resp_bits-1:0]            resp_msg,

  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output logic [p_req_bits-1:0]             mem_req_msg,
  input  logic                              mem_resp_val,
  output logic                              mem_resp_rdy,
  input  logic [p_resp_bits-1:0]            mem_resp_msg,

  output logic [$clog2(p_max_inflight):0]   inflight_count
);

  localparam int c_ptr_bits = $clog2(p_max_inflight);
  localparam int c_cnt_bits = $clog2(p_max_inflight) + 1;

  // Address field position in the packed request (op is the MSB, addr next).
  localparam int c_addr_hi  = p_req_bits - 2;

  logic                  prio;
  logic                  owner_q [p_max_inflight];
  logic [c_ptr_bits-1:0] head;
  logic [c_ptr_bits-1:0] tail;
  logic [c_cnt_bits-1:0] count;

  logic full;
  logic empty;
  logic grant;
  logic owner;
  logic req_xfer;
  logic resp_xfer;

  // NOTE: every signal written in always_comb is given a value on every path;
  // a missing assignment would infer a latch.
  always_comb begin
    full  = (count == c_cnt_bits'(p_max_inflight));
    empty = (count == '0);
    // Conflict goes to prio; otherwise whichever requester is valid (0 when idle).
    grant = (c0_req_val && c1_req_val) ? prio : c1_req_val;
    owner = owner_q[head];

    mem_req_val = (c0_req_val || c1_req_val) && !full;
    mem_req_msg = grant ? c1_req_msg : c0_req_msg;
    c0_req_rdy  = mem_req_rdy && !full && !grant;
    c1_req_rdy  = mem_req_rdy && !full &&  grant;

    // Full blocks requests even if a response pops this cycle, so the request
    // path never depends on the response path.
    req_xfer     = mem_req_val && mem_req_rdy;

    c0_resp_val  = mem_resp_val && !empty && !owner;
    c1_resp_val  = mem_resp_val && !empty &&  owner;
    mem_resp_rdy = !empty && (owner ? c1_resp_rdy : c0_resp_rdy);
    resp_msg     = mem_resp_msg;
    resp_xfer    = mem_resp_val && mem_resp_rdy;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio  <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (req_xfer) begin
        tail <= tail + 1'b1;   // power-of-2 depth: natural wrap
        prio <= ~grant;
      end
      if (resp_xfer) begin
        head <= head + 1'b1;
      end
      case ({req_xfer, resp_xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the owner storage is not reset; entries are only read between
  // head and tail, which reset empties, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (req_xfer) begin
      owner_q[tail] <= grant;
    end
  end

  assign inflight_count = count;

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory broke ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_resp_val && empty));
    end
  end

  // One-line trace: accepted request as owner digit + address, then the
  // owner of the delivered response; blanks of equal width when idle.
  function automatic string line_trace();
    string s_req;
    string s_resp;
    s_req  = req_xfer ? $sformatf("%0d%08h", grant, mem_req_msg[c_addr_hi -: 32])
                      : "         ";
    s_resp = resp_xfer ? $sformatf("%0d", owner) : " ";
    return {s_req, " > ", s_resp};
  endfunction
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle-by-cycle against a queue-based
// reference model of the arbitration and ordering rules.
module tb_mem_port_arbiter;

  localparam int REQ     = 101;
  localparam int RESP    = 101;
  localparam int MAXF    = 4;
  localparam int ADDR_HI = REQ - 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             c0_req_val = 1'b0, c1_req_val = 1'b0;
  logic             c0_req_rdy, c1_req_rdy;
  logic [REQ-1:0]   c0_req_msg = '0, c1_req_msg = '0;
  logic             c0_resp_val, c1_resp_val;
  logic             c0_resp_rdy = 1'b0, c1_resp_rdy = 1'b0;
  logic [RESP-1:0]  resp_msg;
  logic             mem_req_val, mem_resp_rdy;
  logic             mem_req_rdy = 1'b0, mem_resp_val = 1'b0;
  logic [REQ-1:0]   mem_req_msg;
  logic [RESP-1:0]  mem_resp_msg = '0;
  logic [$clog2(MAXF):0] inflight_count;

  always #5 clk = ~clk;

  mem_port_arbiter #(.p_req_bits(REQ), .p_resp_bits(RESP), .p_max_inflight(MAXF)) dut (
    .clk(clk), .rst(rst),
    .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_msg(c0_req_msg),
    .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_msg(c1_req_msg),
    .c0_resp_val(c0_resp_val), .c0_resp_rdy(c0_resp_rdy),
    .c1_resp_val(c1_resp_val), .c1_resp_rdy(c1_resp_rdy),
    .resp_msg(resp_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .inflight_count(inflight_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: owners of outstanding requests, the memory's pending
  // responses (the memory echoes each request back), and the favoured requester.
  bit             m_owners[$];
  logic [REQ-1:0] m_mem[$];
  bit             m_prio;
  bit             resp_en;
  logic [31:0]    a0, a1;
  logic [31:0]    c0_seen[$];
  logic [31:0]    c1_seen[$];
  bit             seen_owner[$];

  function automatic logic [REQ-1:0] make_msg(logic [31:0] addr);
    return {1'($urandom_range(0, 1)), addr, 4'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Present the memory's oldest pending response, then let logic settle.
  task automatic drive();
    mem_resp_val = resp_en && (m_mem.size() != 0);
    mem_resp_msg = (m_mem.size() != 0) ? m_mem[0] : '0;
    #1;
  endtask

  // Compare every output against the model, clock once, update the model.
  task automatic advance();
    bit full, empty, g, own, e_rr, rq, rs;
    logic [REQ-1:0] gmsg;
    logic [REQ-1:0] head_msg;
    full  = (m_owners.size() == MAXF);
    empty = (m_owners.size() == 0);
    g     = (c0_req_val && c1_req_val) ? m_prio : c1_req_val;
    gmsg  = g ? c1_req_msg : c0_req_msg;
    own   = empty ? 1'b0 : m_owners[0];
    e_rr  = !empty && (own ? c1_resp_rdy : c0_resp_rdy);
    check("mem_req_val",    128'(mem_req_val),    128'((c0_req_val || c1_req_val) && !full));
    check("c0_req_rdy",     128'(c0_req_rdy),     128'(mem_req_rdy && !full && !g));
    check("c1_req_rdy",     128'(c1_req_rdy),     128'(mem_req_rdy && !full && g));
    check("mem_req_msg",    128'(mem_req_msg),    128'(gmsg));
    check("c0_resp_val",    128'(c0_resp_val),    128'(mem_resp_val && !empty && !own));
    check("c1_resp_val",    128'(c1_resp_val),    128'(mem_resp_val && !empty && own));
    check("mem_resp_rdy",   128'(mem_resp_rdy),   128'(e_rr));
    check("resp_msg",       128'(resp_msg),       128'(mem_resp_msg));
    check("inflight_count", 128'(inflight_count), 128'(m_owners.size()));
    rq = (c0_req_val || c1_req_val) && !full && mem_req_rdy;
    rs = mem_resp_val && e_rr;
    @(posedge clk);
    if (rs) begin
      head_msg = m_mem[0];
      if (own) c1_seen.push_back(head_msg[ADDR_HI -: 32]);
      else     c0_seen.push_back(head_msg[ADDR_HI -: 32]);
      seen_owner.push_back(own);
      void'(m_owners.pop_front());
      void'(m_mem.pop_front());
    end
    if (rq) begin
      m_owners.push_back(g);
      m_mem.push_back(gmsg);
      m_prio = !g;
    end
    @(negedge clk);
    if (rq) begin
      if (g) begin a1 = a1 + 32'd4; c1_req_msg = make_msg(a1); end
      else   begin a0 = a0 + 32'd4; c0_req_msg = make_msg(a0); end
    end
  endtask

  task automatic step();
    drive();
    advance();
  endtask

  task automatic idle_inputs();
    c0_req_val = 1'b0; c1_req_val = 1'b0; mem_req_rdy = 1'b0;
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0; resp_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_resp_val = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_owners.delete();
    m_mem.delete();
    m_prio = 1'b0;
    seen_owner.delete();
    c0_seen.delete();
    c1_seen.delete();
  endtask

  // Drain all outstanding responses with a cycle budget.
  task automatic drain(string tag);
    int budget;
    idle_inputs();
    resp_en = 1'b1; c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    budget = 50;
    while (m_mem.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_drain_timeout"}, 128'(m_mem.size()), 128'(0));
  endtask

  initial begin
    int budget;
    a0 = 32'h0; a1 = 32'h1000;
    c0_req_msg = make_msg(a0);
    c1_req_msg = make_msg(a1);
    @(negedge clk);
    do_reset();

    // Reset state with all inputs idle.
    drive();
    check("rst_c0_req_rdy",   128'(c0_req_rdy),     128'(0));
    check("rst_c1_req_rdy",   128'(c1_req_rdy),     128'(0));
    check("rst_mem_req_val",  128'(mem_req_val),    128'(0));
    check("rst_c0_resp_val",  128'(c0_resp_val),    128'(0));
    check("rst_c1_resp_val",  128'(c1_resp_val),    128'(0));
    check("rst_mem_resp_rdy", 128'(mem_resp_rdy),   128'(0));
    check("rst_inflight",     128'(inflight_count), 128'(0));
    advance();

    // Only c0 requests 0x200/0x204/0x208; memory answers in order.
    a0 = 32'h200;
    c0_req_msg = make_msg(a0);
    mem_req_rdy = 1'b1; resp_en = 1'b1; c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    budget = 40;
    while ((a0 <= 32'h208 || m_mem.size() != 0) && budget > 0) begin
      c0_req_val = (a0 <= 32'h208);
      step();
      budget--;
    end
    if (budget == 0) check("t1_timeout", 128'(1), 128'(0));
    c0_req_val = 1'b0;
    check("t1_c0_count", 128'(c0_seen.size()), 128'(3));
    check("t1_c1_count", 128'(c1_seen.size()), 128'(0));
    for (int i = 0; i < 3; i++)
      check("t1_c0_addr", 128'((c0_seen.size() > i) ? c0_seen[i] : 32'hx), 128'(32'h200 + 32'(4 * i)));
    drive();
    check("t1_inflight_end", 128'(inflight_count), 128'(0));
    advance();

    // Both valid every cycle after reset: grants alternate 0,1,0,1 until full.
    do_reset();
    c0_req_val = 1'b1; c1_req_val = 1'b1; mem_req_rdy = 1'b1;
    for (int k = 0; k < MAXF; k++) begin
      drive();
      check("alt_c0_req_rdy", 128'(c0_req_rdy), 128'(k % 2 == 0));
      check("alt_c1_req_rdy", 128'(c1_req_rdy), 128'(k % 2 == 1));
      advance();
    end
    // Memory silent: queue is full and nothing more is accepted.
    for (int k = 0; k < 3; k++) begin
      drive();
      check("full_c0_req_rdy",  128'(c0_req_rdy),     128'(0));
      check("full_c1_req_rdy",  128'(c1_req_rdy),     128'(0));
      check("full_mem_req_val", 128'(mem_req_val),    128'(0));
      check("full_inflight",    128'(inflight_count), 128'(MAXF));
      advance();
    end
    // One pop while full: no push that cycle, push the next one.
    resp_en = 1'b1; c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    drive();
    check("pop_full_resp_rdy", 128'(mem_resp_rdy), 128'(1));
    check("pop_full_req_val",  128'(mem_req_val),  128'(0));
    advance();
    resp_en = 1'b0;
    drive();
    check("after_pop_inflight", 128'(inflight_count), 128'(MAXF - 1));
    check("after_pop_c0_rdy",   128'(c0_req_rdy),     128'(1));
    advance();
    drain("alt");
    check("alt_resp_count", 128'(seen_owner.size()), 128'(MAXF + 1));
    for (int i = 0; i < MAXF; i++)
      check("alt_resp_owner", 128'((seen_owner.size() > i) ? seen_owner[i] : 1'bx), 128'(i % 2));

    // Head-of-line blocking: owner 1 at head not ready stalls owner 0 behind it.
    do_reset();
    mem_req_rdy = 1'b1;
    c1_req_val = 1'b1; step();
    c1_req_val = 1'b0; c0_req_val = 1'b1; step();
    c0_req_val = 1'b0;
    resp_en = 1'b1; c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive();
      check("hol_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
      check("hol_c0_resp_val",  128'(c0_resp_val),  128'(0));
      advance();
    end
    check("hol_none_delivered", 128'(seen_owner.size()), 128'(0));
    drain("hol");
    check("hol_count", 128'(seen_owner.size()), 128'(2));
    check("hol_first",  128'((seen_owner.size() > 0) ? seen_owner[0] : 1'bx), 128'(1));
    check("hol_second", 128'((seen_owner.size() > 1) ? seen_owner[1] : 1'bx), 128'(0));

    // Reset with two outstanding (prio left at 1) clears queue and prio.
    do_reset();
    mem_req_rdy = 1'b1; c0_req_val = 1'b1;
    step(); step();
    do_reset();
    drive();
    check("rst2_inflight", 128'(inflight_count), 128'(0));
    advance();
    c0_req_val = 1'b1; c1_req_val = 1'b1; mem_req_rdy = 1'b1;
    drive();
    check("rst2_c0_req_rdy", 128'(c0_req_rdy),  128'(1));
    check("rst2_c1_req_rdy", 128'(c1_req_rdy),  128'(0));
    check("rst2_req_msg",    128'(mem_req_msg), 128'(c0_req_msg));
    advance();
    drain("rst2");

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      c0_req_val  = ($urandom_range(0, 99) < 60);
      c1_req_val  = ($urandom_range(0, 99) < 60);
      mem_req_rdy = ($urandom_range(0, 99) < 75);
      resp_en     = ($urandom_range(0, 99) < 55);
      c0_resp_rdy = ($urandom_range(0, 99) < 70);
      c1_resp_rdy = ($urandom_range(0, 99) < 70);
      step();
    end
    drain("rand");
    drive();
    check("rand_inflight_end", 128'(inflight_count), 128'(0));
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
